// File: rtl/dsc_op_sequencer.sv
// dsc_op_sequencer
// Sequences one deterministic stochastic computing core through complete
// operations: accept operands, hold the core in reset for CLR_CYCLES, run it
// while counting cycles, stop on core completion or cycle budget, then
// present the result until the sink takes it.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake
//   in_data, in_cyc_limit      packed operands, cycle budget (0 = unlimited)
//   abort                      cancel the operation in CLEAR or RUN
//   out_valid/out_ready        result handshake
//   out_data, out_cycles       captured core result, run cycles consumed
//   out_truncated              ended by budget or counter overflow
//   core_rst, core_en          core reset (active high) and enable
//   core_data_in               latched operands to the core
//   core_data_out              core result
//   core_op_finished           core completion flag
//   op_count, trunc_count      saturating statistics
module dsc_op_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [CNT_WIDTH-1:0]             in_cyc_limit,
    input  logic                             abort,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]             out_cycles,
    output logic                             out_truncated,
    output logic                             core_rst,
    output logic                             core_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_out,
    input  logic                             core_op_finished,
    output logic [STAT_WIDTH-1:0]            op_count,
    output logic [STAT_WIDTH-1:0]            trunc_count
);

    localparam int unsigned BusW = NUM_INPUTS * DATA_WIDTH;
    localparam int unsigned ClrW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [ClrW-1:0] ClrLast = ClrW'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [ClrW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  limit_q, limit_d;
    logic [BusW-1:0]       core_data_in_q, core_data_in_d;
    logic [BusW-1:0]       out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]  out_cycles_q, out_cycles_d;
    logic                  out_trunc_q, out_trunc_d;
    logic [STAT_WIDTH-1:0] op_count_q, op_count_d;
    logic [STAT_WIDTH-1:0] trunc_count_q, trunc_count_d;

    // count_q holds cycles already completed; run_cnt is the 1-based index
    // of the current RUN cycle, so the register itself never wraps.
    logic [CNT_WIDTH-1:0] run_cnt;
    logic                 budget_hit;
    logic                 wrap_hit;

    assign run_cnt    = count_q + CNT_WIDTH'(1);
    assign budget_hit = (limit_q != '0) && (run_cnt == limit_q);
    assign wrap_hit   = &run_cnt;

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        count_d        = count_q;
        limit_d        = limit_q;
        core_data_in_d = core_data_in_q;
        out_data_d     = out_data_q;
        out_cycles_d   = out_cycles_q;
        out_trunc_d    = out_trunc_q;
        op_count_d     = op_count_q;
        trunc_count_d  = trunc_count_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    core_data_in_d = in_data;
                    limit_d        = in_cyc_limit;
                    clr_cnt_d      = '0;
                    count_d        = '0;
                    state_d        = StClear;
                end
            end
            StClear: begin
                count_d = '0;
                if (abort) begin
                    state_d = StIdle;
                end else if (clr_cnt_q == ClrLast) begin
                    state_d = StRun;
                end else begin
                    clr_cnt_d = clr_cnt_q + ClrW'(1);
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    count_d = run_cnt;
                    if (core_op_finished || budget_hit || wrap_hit) begin
                        out_data_d   = core_data_out;
                        out_cycles_d = run_cnt;
                        // Completion wins over a coincident budget hit.
                        out_trunc_d  = !core_op_finished;
                        state_d      = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    if (op_count_q != '1) begin
                        op_count_d = op_count_q + STAT_WIDTH'(1);
                    end
                    if (out_trunc_q && (trunc_count_q != '1)) begin
                        trunc_count_d = trunc_count_q + STAT_WIDTH'(1);
                    end
                    state_d = StIdle;
                end
            end
        endcase

        // Registered so in_ready stays low while reset is asserted.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            in_ready_q     <= 1'b0;
            clr_cnt_q      <= '0;
            count_q        <= '0;
            limit_q        <= '0;
            core_data_in_q <= '0;
            out_data_q     <= '0;
            out_cycles_q   <= '0;
            out_trunc_q    <= 1'b0;
            op_count_q     <= '0;
            trunc_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            clr_cnt_q      <= clr_cnt_d;
            count_q        <= count_d;
            limit_q        <= limit_d;
            core_data_in_q <= core_data_in_d;
            out_data_q     <= out_data_d;
            out_cycles_q   <= out_cycles_d;
            out_trunc_q    <= out_trunc_d;
            op_count_q     <= op_count_d;
            trunc_count_q  <= trunc_count_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q == StDone);
    assign out_data      = out_data_q;
    assign out_cycles    = out_cycles_q;
    assign out_truncated = out_trunc_q;
    assign core_rst      = (state_q != StRun);
    assign core_en       = (state_q == StRun);
    assign core_data_in  = core_data_in_q;
    assign op_count      = op_count_q;
    assign trunc_count   = trunc_count_q;

endmodule
